// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART blocks
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam int DATA_BITS = 8;

  // Clocks per oversample tick, rounded to nearest and never below one.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int per_tick;
    int d;
    per_tick = baud * oversample;
    d = (clk_freq + per_tick / 2) / per_tick;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator with synchronous phase reload
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic reload_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == LAST);
    cnt_d  = (reload_i || tick_o) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampling 8N1 UART receiver; define UART_RX_PARITY_CHECK_EN for 8E1/8O1
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_CHECK_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_receive,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(DATA_BITS);
  localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] FULL_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] LAST_BIT  = BIW'(DATA_BITS - 1);

  rx_state_e state_q, state_d;
  logic rx_meta_q, rx_s_q;
  logic [1:0] fill_q;
  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BIW-1:0] bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic dv_q, dv_d, fe_q, fe_d;
  logic armed_q, armed_d, hi_run_q, hi_run_d;
  logic tick, reload, half_done, full_done, stop_ok, sync_ok;
`ifdef UART_RX_PARITY_CHECK_EN
  logic par_err_q, par_err_d;
`endif

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .reload_i (reload),
    .tick_o   (tick)
  );

  // Synchroniser flops reset high; fill_q masks their reset value from the arming logic.
  assign sync_ok   = fill_q[1];
  assign half_done = tick && (tick_cnt_q == HALF_LAST);
  assign full_done = tick && (tick_cnt_q == FULL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rx_s_q && armed_q) state_d = START;
      START:     if (half_done) state_d = rx_s_q ? IDLE : DATA;
      DATA: begin
        if (full_done && bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_CHECK_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_CHECK_EN
      PARITY:    if (full_done) state_d = STOP;
`endif
      STOP:      if (full_done) state_d = rx_s_q ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (tick && rx_s_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    dv_d       = 1'b0;
    fe_d       = 1'b0;
    armed_d    = armed_q;
    hi_run_d   = 1'b0;
    reload     = (state_q == IDLE) && (state_d == START);
`ifdef UART_RX_PARITY_CHECK_EN
    par_err_d  = par_err_q;
    stop_ok    = rx_s_q && !par_err_q;
`else
    stop_ok    = rx_s_q;
`endif
    if (state_d != state_q || full_done) tick_cnt_d = '0;
    else if (tick)                       tick_cnt_d = tick_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        // Arm only after the line has stayed high across a whole tick interval.
        if (rx_s_q && sync_ok) begin
          hi_run_d = hi_run_q | tick;
          if (tick && hi_run_q) armed_d = 1'b1;
        end
      end
      START: begin
        bit_idx_d = '0;
`ifdef UART_RX_PARITY_CHECK_EN
        par_err_d = 1'b0;
`endif
      end
      DATA: begin
        if (full_done) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_CHECK_EN
      PARITY: if (full_done) par_err_d = rx_s_q ^ (^shift_q) ^ PARITY_ODD;
`endif
      STOP: begin
        if (full_done) begin
          if (stop_ok) begin
            data_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            fe_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (fe_d) armed_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      fill_q     <= 2'b00;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      fe_q       <= 1'b0;
      armed_q    <= 1'b0;
      hi_run_q   <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      fill_q     <= {fill_q[0], 1'b1};
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      fe_q       <= fe_d;
      armed_q    <= armed_d;
      hi_run_q   <= hi_run_d;
`ifdef UART_RX_PARITY_CHECK_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign data_receive = data_q;
  assign data_valid   = dv_q;
  assign frame_error  = fe_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - self-checking bench for uart_rx_frame (16 clk per bit)
module tb_uart_rx_frame;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_receive;
  logic       data_valid, frame_error, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] val;
    int         lo;
    int         hi;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] model_last = 8'h00;

  uart_rx_frame #(
    .CLK_FREQ   (16_000_000),
    .BAUD       (1_000_000),
    .OVERSAMPLE (OS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .data_receive (data_receive),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Every pulse must match the oldest outstanding expectation, landing near the stop-bit centre.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid || frame_error) begin
        if (data_valid) dv_cnt++;
        else            fe_cnt++;
        check("dv_fe_exclusive", {31'd0, data_valid & frame_error}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, data_valid, frame_error}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {31'd0, frame_error}, {31'd0, e.is_err});
          check("pulse_in_window", {31'd0, (cyc >= e.lo) && (cyc <= e.hi)}, 32'd1);
          if (!e.is_err) model_last = e.val;
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].hi) begin
        check("missing_pulse", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
      check("data_receive_hold", {24'd0, data_receive}, {24'd0, model_last});
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit use_par, input bit par_b);
    exp_t x;
    int   nb;
    nb       = use_par ? 11 : 10;
    x.is_err = !(stop_b && (!use_par || (par_b == ^d)));
    x.val    = d;
    x.lo     = cyc + nb * OS - OS / 2;
    x.hi     = x.lo + OS / 2;
    exp_q.push_back(x);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (use_par) send_bit(par_b);
    send_bit(stop_b);
  endtask

  task automatic apply_reset(input logic rx_level);
    rst = 1'b1;
    exp_q.delete();
    model_last = 8'h00;
    rx = rx_level;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    repeat (4) @(posedge clk);
    #1;
    check("reset_data", {24'd0, data_receive}, 32'h00);
    check("reset_dv", {31'd0, data_valid}, 32'd0);
    check("reset_fe", {31'd0, frame_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(32);

    send_frame(8'h35, 1'b1, 1'b0, 1'b0);
    idle(16);
    check("lit_0x35", {24'd0, data_receive}, 32'h35);
    check("dv_count_a", dv_cnt, 1);
    check("fe_count_a", fe_cnt, 0);

    send_frame(8'h05, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    idle(16);
    check("lit_0xff", {24'd0, data_receive}, 32'hFF);
    check("dv_count_b2b", dv_cnt, 3);

    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    check("glitch_busy_seen", {31'd0, busy}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("glitch_busy_clear", {31'd0, busy}, 32'd0);
    check("glitch_no_dv", dv_cnt, 3);
    check("glitch_no_fe", fe_cnt, 0);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40 * OS) @(posedge clk);
    #1;
    check("break_fe_once", fe_cnt, 1);
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_data_kept", {24'd0, data_receive}, 32'hFF);
    idle(32);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    idle(16);
    check("lit_0x3c", {24'd0, data_receive}, 32'h3C);
    check("dv_count_break", dv_cnt, 4);
    check("fe_count_break", fe_cnt, 1);

    v = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(v[i]);
    rx = v[4];
    repeat (8) @(posedge clk);
    #1;
    apply_reset(1'b1);
    check("midreset_data", {24'd0, data_receive}, 32'h00);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(32);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle(16);
    check("lit_0x81", {24'd0, data_receive}, 32'h81);
    check("dv_count_reset", dv_cnt, 5);

    apply_reset(1'b0);
    rst = 1'b0;
    repeat (10 * OS) @(posedge clk);
    #1;
    check("low_out_of_reset_busy", {31'd0, busy}, 32'd0);
    check("low_out_of_reset_dv", dv_cnt, 5);
    check("low_out_of_reset_fe", fe_cnt, 1);
    idle(32);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    idle(16);
    check("lit_0xc3", {24'd0, data_receive}, 32'hC3);

`ifdef UART_RX_PARITY_CHECK_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle(32);
    check("par_good_dv", dv_cnt, 7);
    check("lit_par_0x07", {24'd0, data_receive}, 32'h07);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    idle(32);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle(32);
    check("par_bad_fe", fe_cnt, 2);
    check("par_bad_no_dv", dv_cnt, 8);
    check("par_bad_data_kept", {24'd0, data_receive}, 32'hC3);
`endif

    idle(200);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
